// File: rtl/paint_port_arbiter_pkg.sv
// rtl/paint_port_arbiter_pkg.sv - shared canvas constants, engine indices and arbiter state encoding
package paint_port_arbiter_pkg;

  localparam int CANVAS_W   = 64;
  localparam int ENG_CURSOR = 0;
  localparam int ENG_BRUSH  = 1;
  localparam int ENG_CLEAR  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_GAP
  } arb_state_t;

  function automatic int addr_w(input int canvas_w);
    return $clog2(canvas_w) * 2;
  endfunction

endpackage

// File: rtl/paint_port_arbiter_if.sv
// rtl/paint_port_arbiter_if.sv - engine-side and framebuffer-side signals of the paint port arbiter
interface paint_port_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = paint_port_arbiter_pkg::addr_w(paint_port_arbiter_pkg::CANVAS_W)
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   eng_done;
  logic [N_REQ-1:0]   eng_paint;
  logic [8*N_REQ-1:0] eng_px_data;
  logic [8*N_REQ-1:0] eng_x;
  logic [8*N_REQ-1:0] eng_y;
  logic [N_REQ-1:0]   eng_init;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [7:0]         fb_data;
  logic               timeout_err;

  modport master (
    input  req, eng_done, eng_paint, eng_px_data, eng_x, eng_y,
    output eng_init, grant, busy, fb_we, fb_addr, fb_data, timeout_err
  );

  modport slave (
    output req, eng_done, eng_paint, eng_px_data, eng_x, eng_y,
    input  eng_init, grant, busy, fb_we, fb_addr, fb_data, timeout_err
  );

endinterface

// File: rtl/paint_port_arbiter_rr_picker.sv
// rtl/paint_port_arbiter_rr_picker.sv - combinational round-robin winner search starting at rr_ptr
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/paint_port_arbiter.sv
// rtl/paint_port_arbiter.sv - round-robin owner of the canvas write port with clipping and watchdog
module paint_port_arbiter #(
  parameter int N_REQ    = 3,
  parameter int CANVAS_W = paint_port_arbiter_pkg::CANVAS_W,
  parameter int TIMEOUT  = 4096
) (
  input logic                  clk,
  input logic                  rst,
  paint_port_arbiter_if.master bus
);
  import paint_port_arbiter_pkg::*;

  localparam int LW   = $clog2(CANVAS_W);
  localparam int AW   = addr_w(CANVAS_W);
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    rr_ptr, owner, win_idx;
  logic [N_REQ-1:0] winner;
  logic             win_valid;
  logic [WD_W-1:0]  wd_cnt;
  logic             wd_hit, on_canvas;
  logic             sel_paint, sel_done;
  logic [7:0]       sel_x, sel_y, sel_px;

  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_picker (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (winner[k]) win_idx = IW'(k);
    end
  end

  // Only the owning engine's lanes are ever looked at; strays from others fall away here.
  always_comb begin
    int base;
    base      = 8 * int'(owner);
    sel_paint = bus.eng_paint[owner];
    sel_done  = bus.eng_done[owner];
    sel_x     = bus.eng_x[base +: 8];
    sel_y     = bus.eng_y[base +: 8];
    sel_px    = bus.eng_px_data[base +: 8];
  end

  assign on_canvas = (int'(sel_x) < CANVAS_W) && (int'(sel_y) < CANVAS_W);
  assign wd_hit    = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

  assign bus.busy     = (state != ST_IDLE);
  assign bus.eng_init = (state == ST_START) ? bus.grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (win_valid) state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN:   if (sel_done || wd_hit) state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr          <= '0;
      owner           <= '0;
      wd_cnt          <= '0;
      bus.grant       <= '0;
      bus.fb_we       <= 1'b0;
      bus.fb_addr     <= '0;
      bus.fb_data     <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      // A done in the same cycle as the last watchdog count is a clean finish, not an abort.
      bus.timeout_err <= (state == ST_RUN) && wd_hit && !sel_done;
      bus.fb_we       <= (state == ST_RUN) && sel_paint && on_canvas;
      if ((state == ST_RUN) && sel_paint) begin
        bus.fb_addr <= AW'({sel_y[LW-1:0], sel_x[LW-1:0]});
        bus.fb_data <= sel_px;
      end
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            owner     <= win_idx;
            bus.grant <= winner;
          end
        end
        ST_START: wd_cnt <= '0;
        ST_RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (state_nxt == ST_GAP) bus.grant <= '0;
        end
        ST_GAP:  rr_ptr <= (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_port_arbiter.sv
// tb/tb_paint_port_arbiter.sv - directed and randomized checks of paint_port_arbiter against a job-level model
module tb_paint_port_arbiter;
  import paint_port_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int CW = 64;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  paint_port_arbiter_if #(.N_REQ(N)) bus ();

  paint_port_arbiter #(.N_REQ(N), .CANVAS_W(CW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: who owns the port, how long it has held it, and whether it is in the dead cycle.
  int         m_owner = -1;
  int         m_age   = 0;
  int         m_ptr   = 0;
  bit         m_gap   = 1'b0;
  bit         e_we    = 1'b0;
  bit         e_to    = 1'b0;
  logic [11:0] e_addr = '0;
  logic [7:0]  e_data = '0;

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_ptr = 0; m_gap = 1'b0;
    e_we = 1'b0; e_to = 1'b0; e_addr = '0; e_data = '0;
  endtask

  task automatic model_step();
    int xv, yv, w;
    e_we = 1'b0;
    e_to = 1'b0;
    if (m_owner >= 0 && !m_gap && m_age >= 1 && bus.eng_paint[m_owner]) begin
      xv     = int'(bus.eng_x[8*m_owner +: 8]);
      yv     = int'(bus.eng_y[8*m_owner +: 8]);
      e_we   = (xv < CW) && (yv < CW);
      e_addr = 12'(yv * CW + xv);
      e_data = bus.eng_px_data[8*m_owner +: 8];
    end
    if (m_owner < 0) begin
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin m_owner = w; m_age = 0; m_gap = 1'b0; end
    end else if (m_gap) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_gap   = 1'b0;
    end else if (m_age == 0) m_age = 1;
    else if (bus.eng_done[m_owner]) m_gap = 1'b1;
    else if (m_age == TO) begin m_gap = 1'b1; e_to = 1'b1; end
    else m_age++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else      model_step();
  end

  initial forever begin
    logic [N-1:0] eg, ei;
    @(negedge clk);
    if (rst) begin
      eg = (m_owner >= 0 && !m_gap) ? N'(1 << m_owner) : '0;
      ei = (m_owner >= 0 && !m_gap && m_age == 0) ? N'(1 << m_owner) : '0;
      chk("m_busy", bus.busy, (m_owner >= 0));
      chk("m_grant", bus.grant, eg);
      chk("m_eng_init", bus.eng_init, ei);
      chk("m_fb_we", bus.fb_we, e_we);
      chk("m_timeout_err", bus.timeout_err, e_to);
      if (e_we) begin
        chk("m_fb_addr", bus.fb_addr, e_addr);
        chk("m_fb_data", bus.fb_data, e_data);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_eng();
    bus.eng_done  = '0;
    bus.eng_paint = '0;
  endtask

  task automatic set_px(input int e, input int x, input int y, input logic [7:0] c);
    bus.eng_paint[e]           = 1'b1;
    bus.eng_x[8*e +: 8]       = 8'(x);
    bus.eng_y[8*e +: 8]       = 8'(y);
    bus.eng_px_data[8*e +: 8] = c;
  endtask

  task automatic wait_init(input int e, output int cycles);
    cycles = 0;
    while (bus.eng_init == '0 && cycles < 50) begin
      tick();
      cycles++;
    end
    chk("init_owner", bus.eng_init, 32'(1 << e));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_eng_init"}, bus.eng_init, 0);
    chk({tag, "_fb_we"}, bus.fb_we, 0);
    chk({tag, "_fb_addr"}, bus.fb_addr, 0);
    chk({tag, "_fb_data"}, bus.fb_data, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    bus.req = '0; clr_eng();
    bus.eng_px_data = '0; bus.eng_x = '0; bus.eng_y = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b1;

    // single cursor job
    bus.req = 3'b001;
    wait_init(ENG_CURSOR, c);
    chk("grant_latency", c, 1);
    chk("busy_at_start", bus.busy, 1);
    tick();
    chk("init_one_cycle", bus.eng_init, 0);
    set_px(0, 10, 20, 8'h5A);
    tick();
    chk("single_we", bus.fb_we, 1);
    chk("single_addr", bus.fb_addr, 12'h50A);
    chk("single_data", bus.fb_data, 8'h5A);
    clr_eng(); bus.eng_done[0] = 1'b1; bus.req = '0;
    tick();
    chk("gap_busy", bus.busy, 1);
    chk("gap_grant", bus.grant, 0);
    clr_eng();
    tick();
    chk("busy_fall", bus.busy, 0);

    // clipping and stray engine activity on a brush job
    bus.req = 3'b010;
    wait_init(ENG_BRUSH, c);
    tick();
    set_px(1, 70, 5, 8'h11);  tick(); chk("clip_x", bus.fb_we, 0);
    set_px(1, 5, 64, 8'h22);  tick(); chk("clip_y", bus.fb_we, 0);
    set_px(1, 63, 63, 8'hC3); tick();
    chk("edge_we", bus.fb_we, 1);
    chk("edge_addr", bus.fb_addr, 12'hFFF);
    chk("edge_data", bus.fb_data, 8'hC3);
    clr_eng(); set_px(0, 1, 1, 8'h33); set_px(2, 2, 2, 8'h44); bus.eng_paint[1] = 1'b0;
    bus.eng_done = 3'b101;
    tick();
    chk("stray_we", bus.fb_we, 0);
    chk("stray_grant", bus.grant, 3'b010);
    chk("stray_busy", bus.busy, 1);
    clr_eng(); bus.eng_done[1] = 1'b1; bus.req = '0;
    tick(); clr_eng(); tick();

    // watchdog on a hung clear engine
    bus.req = 3'b100;
    wait_init(ENG_CLEAR, c);
    bus.req = 3'b101;
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk("wd_running", {bus.timeout_err, bus.grant}, 4'b0100);
    end
    tick();
    chk("wd_err", bus.timeout_err, 1);
    chk("wd_gap_grant", bus.grant, 0);
    tick();
    chk("wd_err_pulse", bus.timeout_err, 0);
    wait_init(ENG_CURSOR, c);
    chk("wd_next_served", c, 1);
    tick();
    bus.eng_done[0] = 1'b1; bus.req = '0;
    tick(); clr_eng(); tick();

    // reset in the middle of a job
    bus.req = 3'b100;
    wait_init(ENG_CLEAR, c);
    tick();
    set_px(2, 3, 4, 8'h77);
    tick();
    chk("pre_reset_we", bus.fb_we, 1);
    chk("pre_reset_addr", bus.fb_addr, 12'h103);
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    tick(); tick();
    clr_eng(); bus.req = 3'b111;
    rst = 1'b1;

    // contention: pointer restarts at 0
    for (int j = 0; j < 6; j++) begin
      wait_init(j % 3, c);
      if (j > 0) chk("job_spacing", c + 1, 3);
      tick();
      bus.eng_done[j % 3] = 1'b1;
      tick();
      clr_eng();
    end
    bus.req = '0;
    tick(); tick();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.req       = 3'($urandom_range(0, 7));
      bus.eng_paint = 3'($urandom_range(0, 7));
      for (int e = 0; e < N; e++) begin
        bus.eng_done[e]           = ($urandom_range(0, 7) == 0);
        bus.eng_x[8*e +: 8]       = 8'($urandom_range(0, 79));
        bus.eng_y[8*e +: 8]       = 8'($urandom_range(0, 79));
        bus.eng_px_data[8*e +: 8] = 8'($urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/paint_port_arbiter.md
# paint_port_arbiter

Round-robin scheduler that shares the single canvas framebuffer write port between `N_REQ` pixel-drawing engines (cursor overlay, brush stroke, canvas clear). Each engine follows the same `init` pulse / `done` pulse job protocol as the cursor drawer and emits `paint`, `px_data`, `out_x`, `out_y`. The arbiter starts exactly one engine at a time, forwards its writes to the framebuffer with clipping, and recovers from a hung engine with a watchdog. It sits between the paint engines and the canvas RAM inside the paint top level.

## Interface
- `N_REQ`, 3, number of engines; index 0 = cursor, 1 = brush, 2 = clear
- `CANVAS_W`, 64, canvas width and height in pixels; power of two
- `TIMEOUT`, 4096, max cycles in RUN before abort; 0 disables the watchdog
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  level request per engine, held until granted job completes
- `eng_done`  in  N_REQ  engine job-complete pulse (`cursor_done` etc.)
- `eng_paint`  in  N_REQ  engine pixel-write strobe
- `eng_px_data`  in  8*N_REQ  engine pixel colour, engine i at [8i+7:8i]
- `eng_x`, `eng_y`  in  8*N_REQ  engine pixel coordinates, same packing
- `eng_init`  out  N_REQ  one-cycle start pulse to the granted engine
- `grant`  out  N_REQ  one-hot owner, non-zero in START and RUN
- `busy`  out  1  high in any state except IDLE
- `fb_we`  out  1  framebuffer write enable
- `fb_addr`  out  12  `{y[5:0], x[5:0]}` for default `CANVAS_W`
- `fb_data`  out  8  framebuffer write colour
- `timeout_err`  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, START, RUN, GAP.
- IDLE: if any `req` is set, pick the first set bit at or after `rr_ptr`, wrapping, then go to START. Otherwise stay in IDLE.
- START: load `grant`, pulse `eng_init[g]` for this one cycle, clear the watchdog counter, then go to RUN.
- RUN: forward engine g's `eng_paint`, `eng_px_data`, `eng_x`, `eng_y` to the framebuffer.
  - On `eng_done[g]`, go to GAP.
  - If the watchdog counter reaches `TIMEOUT`, pulse `timeout_err` and go to GAP.
- GAP: one dead cycle. Set `rr_ptr` to (g+1) mod `N_REQ`, clear `grant`, then go to IDLE.
- Clipping: when `eng_x >= CANVAS_W` or `eng_y >= CANVAS_W`, suppress `fb_we`. `fb_addr` and `fb_data` still update and are don't-care.
- Ignored inputs:
  - `eng_paint` and `eng_done` from non-granted engines.
  - `eng_done[g]` during START.
  - `req` changes after grant; a dropped `req` does not abort the job.
- Simultaneous requests: the round-robin pointer decides. Over repeated contention every requester is served within `N_REQ` jobs.
- Reset (any time, including mid-job) forces IDLE, `rr_ptr`=0 and every output to 0. The interrupted engine is not notified.

## Timing
- Reset values: `eng_init`, `grant`, `busy`, `fb_we`, `fb_addr`, `fb_data`, `timeout_err` are all 0.
- Grant latency: `req` high in IDLE at edge t gives START (with `eng_init` high) in cycle t+1 and RUN from t+2. `busy` rises with START.
- Write path is registered. Engine `paint` in RUN cycle c produces `fb_we`/`fb_addr`/`fb_data` in cycle c+1.
  - A `paint` coincident with `done` is still written, in the GAP cycle.
- Back-to-back jobs: minimum spacing of 3 idle-to-init cycles, counted as GAP, IDLE, then START of the next job.
- Watchdog counts RUN cycles only. Abort happens at RUN cycle number `TIMEOUT`, and `timeout_err` is high in that cycle's successor (GAP).
- `busy` falls on the IDLE cycle after GAP.

## Structure
- Shared paint package holds `CANVAS_W`, the address-width function (`$clog2(CANVAS_W)*2`), the engine index constants `ENG_CURSOR`=0, `ENG_BRUSH`=1, `ENG_CLEAR`=2, and the state encoding.
- One sub-module, `rr_picker`, is combinational. Inputs: `req` and `rr_ptr`. Outputs: one-hot winner and a valid flag.
- The FSM, watchdog, output mux and clip logic stay in the top module.

## Test plan
- Single request: `req`=001 with cursor engine at x=10, y=20 -> `eng_init[0]` pulses once. Cursor pixels appear on `fb_we` one cycle after `paint`, with `fb_addr`={20,10}-based offsets. After `cursor_done`, `busy` falls 2 cycles later.
- Contention: `req`=111 held through 6 jobs -> grant order 0,1,2,0,1,2. Each job starts 3 cycles after the previous `done`.
- Clipping: engine drives x=70, y=5 with `paint`=1 -> no `fb_we`. x=63, y=63 -> `fb_we`=1 with `fb_addr`=12'hFFF.
- Watchdog with `TIMEOUT`=16: granted engine never asserts `done` -> `timeout_err` pulses at RUN cycle 16+1 and the next requester is served.
- Stray signals: non-granted engine pulses `paint` and `done` during RUN -> no framebuffer write and no state change.
- Reset mid-job: deassert `rst` during RUN -> all outputs 0 asynchronously. After release, `req`=010 is granted to engine 1 (pointer back at 0).
